trace_capture_buffer: RTL and testbench

- Synthesizable successor to bench-side console monitoring of the CPU LED bus.
- Samples a WIDTH-bit observed bus every clock and stores each value change, tagged with a free-running timestamp, in a DEPTH-entry first-word-fall-through buffer.
- Entries are drained through a valid/ready read port and tracked with overflow accounting.
- Sits between the cpu output bus (led_out) and a debug readout path or self-checking bench.

---
 rtl/trace_capture_buffer.sv | 125 ++++++++++++
 tb/tb_trace_capture_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Change-only trace recorder: timestamps every change on an observed bus into a FWFT buffer.
// Optional TRACE_MASK_EN adds an obs_mask port that limits which bits count as a change.
module trace_capture_buffer #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         obs_in,
`ifdef TRACE_MASK_EN
  input  logic [WIDTH-1:0]         obs_mask,
`endif
  input  logic                     capture_en,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_WIDTH-1:0]      rd_ts,
  output logic [WIDTH-1:0]         rd_value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_WIDTH-1:0]    drop_count,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TS_WIDTH + WIDTH;

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  first_q, first_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic                  changed;
  logic                  event_hit;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [DROP_WIDTH-1:0] drop_base;
  logic [EW-1:0]         wr_entry;
  logic [EW-1:0]         head;

  // Event detection and buffer bookkeeping
  always_comb begin
`ifdef TRACE_MASK_EN
    changed = ((obs_in ^ prev_q) & obs_mask) != '0;
`else
    changed = obs_in != prev_q;
`endif
    event_hit = capture_en & (first_q | changed);
    full      = level_q == LW'(DEPTH);
    pop       = (level_q != '0) & rd_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts the event
    push      = event_hit & (~full | pop);
    drop      = event_hit & full & ~pop;
    wr_entry  = {ts_q, obs_in};

    ts_d     = ts_q + TS_WIDTH'(1);
    prev_d   = capture_en ? obs_in : prev_q;
    first_d  = capture_en ? 1'b0 : first_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Overflow accounting: clear takes effect before a same-edge drop is counted
  always_comb begin
    drop_base  = clear_ovf ? '0 : drop_q;
    drop_d     = drop_base;
    overflow_d = clear_ovf ? 1'b0 : overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_base != {DROP_WIDTH{1'b1}}) begin
        drop_d = drop_base + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is data-only; stale contents are never visible because level gates rd_valid
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    rd_valid   = level_q != '0;
    rd_ts      = head[EW-1:WIDTH];
    rd_value   = head[WIDTH-1:0];
    level      = level_q;
    overflow   = overflow_q;
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomised and directed bench for trace_capture_buffer against a queue-based reference model.
module tb_trace_capture_buffer;

  logic        clock;
  logic        reset;
  logic [15:0] obs_in;
  logic        capture_en;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_ts;
  logic [15:0] rd_value;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_ovf;
`ifdef TRACE_MASK_EN
  logic [15:0] obs_mask;
`endif

  logic [15:0] obs4;
  logic        cap4;
  logic        ready4;
  logic        valid4;
  logic [3:0]  ts4;
  logic [15:0] value4;
  logic [2:0]  level4;
  logic        overflow4;
  logic [7:0]  drop4;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [15:0] ts_m;
  logic [15:0] prev_m;
  bit          first_m;
  bit          ovf_m;
  int          drop_m;
  int          ts4_m;

  trace_capture_buffer dut (
    .clock(clock), .reset(reset), .obs_in(obs_in),
`ifdef TRACE_MASK_EN
    .obs_mask(obs_mask),
`endif
    .capture_en(capture_en), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_ts(rd_ts), .rd_value(rd_value), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  trace_capture_buffer #(.TS_WIDTH(4), .DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .obs_in(obs4),
`ifdef TRACE_MASK_EN
    .obs_mask(16'hFFFF),
`endif
    .capture_en(cap4), .rd_valid(valid4), .rd_ready(ready4),
    .rd_ts(ts4), .rd_value(value4), .level(level4), .overflow(overflow4),
    .drop_count(drop4), .clear_ovf(1'b0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock edge, updating the model from the inputs seen at that edge
  task automatic cycle();
    bit ev;
    bit differs;
    if (!reset) begin
      q.delete();
      ts_m = 16'h0; prev_m = 16'h0; first_m = 1; ovf_m = 0; drop_m = 0; ts4_m = 0;
    end else begin
`ifdef TRACE_MASK_EN
      differs = ((obs_in ^ prev_m) & obs_mask) != 16'h0;
`else
      differs = obs_in != prev_m;
`endif
      ev = capture_en && (first_m || differs);
      if (clear_ovf) begin ovf_m = 0; drop_m = 0; end
      if (rd_ready && q.size() > 0) void'(q.pop_front());
      if (ev) begin
        if (q.size() < 8) q.push_back({ts_m, obs_in});
        else begin
          ovf_m = 1;
          if (drop_m < 255) drop_m++;
        end
      end
      if (capture_en) begin prev_m = obs_in; first_m = 0; end
      ts_m = ts_m + 16'h1;
      ts4_m = (ts4_m + 1) % 16;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; capture_en = 0; rd_ready = 0; clear_ovf = 0; obs_in = 16'h0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; capture_en = 1; obs_in = 16'h1234; rd_ready = 0;
    cycle();
    do_reset();
    checks++;
    if (rd_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b level=%0d ovf=%b drop=%0d, need 0/0/0/0",
               rd_valid, level, overflow, drop_count);
    end
  endtask

  task automatic test_first_sample();
    do_reset();
    capture_en = 1; obs_in = 16'h0;
    repeat (3) cycle();
    checks++;
    if (level !== 4'd1 || rd_valid !== 1'b1 || rd_ts !== 16'd0 || rd_value !== 16'd0) begin
      failures++;
      $display("FAIL first_sample: got level=%0d valid=%b ts=%0d val=%h, need 1/1/0/0000",
               level, rd_valid, rd_ts, rd_value);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] pattern [8];
    logic [31:0] want [3];
    pattern = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h5, 16'h5, 16'h5, 16'h9};
    want = '{{16'd0, 16'h0}, {16'd4, 16'h5}, {16'd7, 16'h9}};
    do_reset();
    capture_en = 1;
    for (int i = 0; i < 8; i++) begin
      obs_in = pattern[i];
      cycle();
    end
    checks++;
    if (level !== 4'd3) begin
      failures++;
      $display("FAIL seq_level: got %0d, need 3", level);
    end
    capture_en = 0; rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || {rd_ts, rd_value} !== want[i]) begin
        failures++;
        $display("FAIL seq_entry%0d: got valid=%b ts=%0d val=%h, need ts=%0d val=%h",
                 i, rd_valid, rd_ts, rd_value, want[i][31:16], want[i][15:0]);
      end
      cycle();
    end
    checks++;
    if (level !== 4'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_drained: got level=%0d valid=%b, need 0/0", level, rd_valid);
    end
    cycle();
    checks++;
    if (level !== 4'd0) begin
      failures++;
      $display("FAIL empty_pop: got level=%0d, need 0", level);
    end
    rd_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    capture_en = 1; rd_ready = 0;
    for (int i = 0; i < 11; i++) begin
      obs_in = 16'(i & 1);
      cycle();
    end
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd3) begin
      failures++;
      $display("FAIL ovf_fill: got level=%0d ovf=%b drop=%0d, need 8/1/3", level, overflow, drop_count);
    end
    rd_ready = 1; obs_in = 16'h1;
    cycle();
    checks++;
    if (level !== 4'd8 || drop_count !== 8'd3 || rd_ts !== q[0][31:16]) begin
      failures++;
      $display("FAIL ovf_pop_push: got level=%0d drop=%0d ts=%0d, need 8/3/%0d",
               level, drop_count, rd_ts, q[0][31:16]);
    end
    rd_ready = 0; capture_en = 0; clear_ovf = 1;
    cycle();
    clear_ovf = 0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%b drop=%0d, need 0/0", overflow, drop_count);
    end
    capture_en = 1; obs_in = 16'h0; clear_ovf = 1;
    cycle();
    clear_ovf = 0;
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL ovf_clear_drop: got ovf=%b drop=%0d, need 1/1", overflow, drop_count);
    end
    for (int i = 0; i < 300; i++) begin
      obs_in = 16'(i & 1) ^ 16'h1;
      cycle();
    end
    checks++;
    if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL drop_saturate: got drop=%0d ovf=%b, need 255/1", drop_count, overflow);
    end
    capture_en = 0;
  endtask

  task automatic test_ts_wrap();
    int budget;
    do_reset();
    cap4 = 1; obs4 = 16'h0; ready4 = 0;
    cycle();
    budget = 0;
    while (ts4_m != 15 && budget < 40) begin cycle(); budget++; end
    obs4 = 16'h1;
    cycle();
    while (ts4_m != 1 && budget < 40) begin cycle(); budget++; end
    obs4 = 16'h2;
    cycle();
    cap4 = 0;
    checks++;
    if (level4 !== 3'd3 || budget >= 40) begin
      failures++;
      $display("FAIL ts_wrap_level: got level=%0d budget=%0d, need 3", level4, budget);
    end
    ready4 = 1;
    checks++;
    if (ts4 !== 4'd0 || value4 !== 16'h0) begin
      failures++;
      $display("FAIL ts_wrap_e0: got ts=%0d val=%h, need 0/0000", ts4, value4);
    end
    cycle();
    checks++;
    if (ts4 !== 4'd15 || value4 !== 16'h1) begin
      failures++;
      $display("FAIL ts_wrap_e1: got ts=%0d val=%h, need 15/0001", ts4, value4);
    end
    cycle();
    checks++;
    if (ts4 !== 4'd1 || value4 !== 16'h2) begin
      failures++;
      $display("FAIL ts_wrap_e2: got ts=%0d val=%h, need 1/0002", ts4, value4);
    end
    cycle();
    ready4 = 0;
    checks++;
    if (valid4 !== 1'b0 || overflow4 !== 1'b0 || drop4 !== 8'd0) begin
      failures++;
      $display("FAIL ts_wrap_end: got valid=%b ovf=%b drop=%0d, need 0/0/0", valid4, overflow4, drop4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    capture_en = 1;
    for (int i = 1; i <= 4; i++) begin
      obs_in = 16'(i);
      cycle();
    end
    reset = 0;
    cycle();
    checks++;
    if (level !== 4'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_flush: got level=%0d valid=%b, need 0/0", level, rd_valid);
    end
    reset = 1; obs_in = 16'hA;
    repeat (3) cycle();
    checks++;
    if (level !== 4'd1 || rd_value !== 16'hA || rd_ts !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_recapture: got level=%0d val=%h ts=%0d, need 1/000a/0",
               level, rd_value, rd_ts);
    end
    capture_en = 0;
  endtask

`ifdef TRACE_MASK_EN
  task automatic test_mask();
    do_reset();
    obs_mask = 16'h00FF; capture_en = 1;
    obs_in = 16'h0000; cycle();
    obs_in = 16'h1200; cycle();
    obs_in = 16'h1234; cycle();
    capture_en = 0;
    checks++;
    if (level !== 4'd2 || rd_value !== 16'h0000) begin
      failures++;
      $display("FAIL mask_first: got level=%0d val=%h, need 2/0000", level, rd_value);
    end
    rd_ready = 1; cycle(); rd_ready = 0;
    checks++;
    if (rd_value !== 16'h1234 || level !== 4'd1) begin
      failures++;
      $display("FAIL mask_second: got level=%0d val=%h, need 1/1234", level, rd_value);
    end
    obs_mask = 16'hFFFF;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) != 0);
      capture_en = ($urandom_range(0, 3) != 0);
      obs_in     = 16'($urandom_range(0, 3)) << ($urandom_range(0, 1) * 8);
      rd_ready   = ($urandom_range(0, 2) == 0);
      clear_ovf  = ($urandom_range(0, 31) == 0);
      cycle();
      checks++;
      if (level !== 4'(q.size()) || rd_valid !== (q.size() > 0) ||
          overflow !== ovf_m || drop_count !== 8'(drop_m)) begin
        failures++;
        $display("FAIL rand_ctrl@%0d: got level=%0d valid=%b ovf=%b drop=%0d, need %0d/%0b/%0b/%0d",
                 i, level, rd_valid, overflow, drop_count, q.size(), q.size() > 0, ovf_m, drop_m);
      end
      if (q.size() > 0) begin
        checks++;
        if ({rd_ts, rd_value} !== q[0]) begin
          failures++;
          $display("FAIL rand_head@%0d: got ts=%0d val=%h, need ts=%0d val=%h",
                   i, rd_ts, rd_value, q[0][31:16], q[0][15:0]);
        end
      end
    end
    reset = 1; capture_en = 0; rd_ready = 0; clear_ovf = 0;
  endtask

  initial begin
    reset = 1'b0; obs_in = 16'h0; capture_en = 0; rd_ready = 0; clear_ovf = 0;
    obs4 = 16'h0; cap4 = 0; ready4 = 0;
`ifdef TRACE_MASK_EN
    obs_mask = 16'hFFFF;
`endif
    q.delete();
    ts_m = 16'h0; prev_m = 16'h0; first_m = 1; ovf_m = 0; drop_m = 0; ts4_m = 0;
    test_reset();
    test_first_sample();
    test_sequence();
    test_overflow();
    test_ts_wrap();
    test_reset_mid();
`ifdef TRACE_MASK_EN
    test_mask();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
